// File: rtl/memory_stage_v2.sv
// Load/store memory stage with a single-beat data bus and a registered
// writeback port.
//
// Every operation is accepted in IDLE. Non-memory and misaligned operations
// are answered in the next cycle without touching the bus. Aligned loads and
// stores move to BUS, which holds one request until the response arrives or
// the wait counter expires.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | ready for a new operation once writeback is not stalled
//   BUS   | request outstanding; or, with done set, a finished result waiting
//         | for the writeback stall to clear
module memory_stage_v2 #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_base,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [4:0]        ex_rd,
    input  logic [XLEN-1:0]   ex_rd_data,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [1:0]        ex_width,
    input  logic              ex_unsigned,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp,

    output logic              wb_valid,
    input  logic              wb_stall,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [1:0]        wb_exc
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Counter starts at TIMEOUT-1 so terminal count (zero) lands on the
    // TIMEOUT-th request cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    // captured operation
    logic              op_we;
    logic [XLEN-1:0]   op_addr;
    logic [OFF_W-1:0]  op_off;
    logic [1:0]        op_width;
    logic              op_uns;
    logic [4:0]        op_rd;
    logic [CNT_W-1:0]  cnt;

    // result parked while writeback is stalled
    logic              done;
    logic [XLEN-1:0]   pend_data;
    logic [1:0]        pend_exc;
    logic [4:0]        pend_rd;

    // acceptance-side decode
    logic              wb_free;
    logic              accept;
    logic              mem_op;
    logic              misalign;
    logic [XLEN-1:0]   ea;
    logic [2:0]        size_m1;
    logic [NB-1:0]     lane_mask;
    logic [NB-1:0]     be_new;
    logic [XLEN-1:0]   wd_rep;

    // response-side decode
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   ld_ext;
    logic              bus_resp;
    logic              bus_tmo;
    logic [XLEN-1:0]   res_data;
    logic [1:0]        res_exc;
    logic [4:0]        res_rd;

    // FSM control outputs
    logic              wb_set;
    logic [XLEN-1:0]   wb_set_data;
    logic [1:0]        wb_set_exc;
    logic [4:0]        wb_set_rd;
    logic              pend_set;
    logic              pend_clr;

    assign wb_free   = !(wb_valid && wb_stall);
    assign ex_ready  = (state == IDLE) && wb_free && !rst;
    assign accept    = ex_valid && ex_ready;
    assign mem_op    = ex_load || ex_store;
    assign ea        = ex_base + ex_imm;
    assign dmem_req  = (state == BUS) && !done;
    assign dmem_addr = op_addr & ~XLEN'(NB - 1);

    // Size decode, misalignment, byte enables and lane-replicated store data.
    always_comb begin
        size_m1   = 3'd0;
        lane_mask = NB'(8'h01);
        case (ex_width)
            2'd0: begin size_m1 = 3'd0; lane_mask = NB'(8'h01); end
            2'd1: begin size_m1 = 3'd1; lane_mask = NB'(8'h03); end
            2'd2: begin size_m1 = 3'd3; lane_mask = NB'(8'h0F); end
            default: begin size_m1 = 3'd7; lane_mask = NB'(8'hFF); end
        endcase
        // A doubleword has no legal alignment on a 32-bit bus.
        misalign = mem_op && (((ea[2:0] & size_m1) != 3'd0) ||
                              ((ex_width == 2'd3) && (XLEN == 32)));
        be_new   = lane_mask << ea[OFF_W-1:0];
        wd_rep   = '0;
        for (int i = 0; i < NB; i++) begin
            wd_rep[8*i +: 8] = ex_wdata[8*(i & int'(size_m1)) +: 8];
        end
    end

    // Align the read lanes down to bit 0 and extend to full width.
    always_comb begin
        rd_shift = dmem_rdata >> {op_off, 3'b000};
        case (op_width)
            2'd0:    ld_ext = op_uns ? XLEN'(rd_shift[7:0])  : XLEN'($signed(rd_shift[7:0]));
            2'd1:    ld_ext = op_uns ? XLEN'(rd_shift[15:0]) : XLEN'($signed(rd_shift[15:0]));
            2'd2:    ld_ext = op_uns ? XLEN'(rd_shift[31:0]) : XLEN'($signed(rd_shift[31:0]));
            default: ld_ext = rd_shift;
        endcase
    end

    // Outcome of the outstanding request this cycle.
    always_comb begin
        bus_resp = (state == BUS) && !done && dmem_resp;
        bus_tmo  = (TIMEOUT > 0) && (state == BUS) && !done && !dmem_resp && (cnt == '0);
        res_data = op_addr;
        res_exc  = EXC_TIMEOUT;
        res_rd   = 5'd0;
        if (bus_resp) begin
            res_exc  = EXC_NONE;
            res_data = op_we ? '0 : ld_ext;
            res_rd   = op_we ? 5'd0 : op_rd;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and writeback/park decisions.
    always_comb begin
        state_next  = state;
        wb_set      = 1'b0;
        wb_set_data = '0;
        wb_set_exc  = EXC_NONE;
        wb_set_rd   = 5'd0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mem_op && !misalign) begin
                        state_next = BUS;
                    end else if (misalign) begin
                        wb_set      = 1'b1;
                        wb_set_data = ea;
                        wb_set_exc  = EXC_MISALIGN;
                    end else begin
                        wb_set      = 1'b1;
                        wb_set_data = ex_rd_data;
                        wb_set_rd   = ex_rd;
                    end
                end
            end
            BUS: begin
                if (done) begin
                    if (wb_free) begin
                        wb_set      = 1'b1;
                        wb_set_data = pend_data;
                        wb_set_exc  = pend_exc;
                        wb_set_rd   = pend_rd;
                        pend_clr    = 1'b1;
                        state_next  = IDLE;
                    end
                end else if (bus_resp || bus_tmo) begin
                    if (wb_free) begin
                        wb_set      = 1'b1;
                        wb_set_data = res_data;
                        wb_set_exc  = res_exc;
                        wb_set_rd   = res_rd;
                        state_next  = IDLE;
                    end else begin
                        pend_set = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the accepted operation and drive the bus request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_we      <= 1'b0;
            op_addr    <= '0;
            op_off     <= '0;
            op_width   <= 2'd0;
            op_uns     <= 1'b0;
            op_rd      <= 5'd0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else if (accept) begin
            op_we      <= ex_store;
            op_addr    <= ea;
            op_off     <= ea[OFF_W-1:0];
            op_width   <= ex_width;
            op_uns     <= ex_unsigned;
            op_rd      <= ex_rd;
            dmem_be    <= be_new;
            dmem_wdata <= wd_rep;
        end
    end

    assign dmem_we = op_we;

    // Bus-wait down-counter; reloaded on every acceptance.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (accept)
            cnt <= CNT_LOAD;
        else if ((state == BUS) && !done && !dmem_resp && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    // Park a finished bus result while writeback is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            pend_data <= '0;
            pend_exc  <= EXC_NONE;
            pend_rd   <= 5'd0;
        end else if (pend_set) begin
            done      <= 1'b1;
            pend_data <= res_data;
            pend_exc  <= res_exc;
            pend_rd   <= res_rd;
        end else if (pend_clr) begin
            done      <= 1'b0;
        end
    end

    // Writeback register: load a new result, or retire the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= '0;
            wb_exc   <= EXC_NONE;
        end else if (wb_set) begin
            wb_valid <= 1'b1;
            wb_rd    <= wb_set_rd;
            wb_data  <= wb_set_data;
            wb_exc   <= wb_set_exc;
        end else if (wb_valid && !wb_stall) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage_v2.sv
// Directed bench for memory_stage_v2 (XLEN=32, TIMEOUT=4).
module tb_memory_stage_v2;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_base;
    logic [31:0] ex_imm;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rd_data;
    logic        ex_load;
    logic        ex_store;
    logic [1:0]  ex_width;
    logic        ex_unsigned;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        wb_valid;
    logic        wb_stall;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    int checks = 0;
    int errors = 0;

    memory_stage_v2 #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_base(ex_base), .ex_imm(ex_imm), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_rd_data(ex_rd_data),
        .ex_load(ex_load), .ex_store(ex_store), .ex_width(ex_width), .ex_unsigned(ex_unsigned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .wb_valid(wb_valid), .wb_stall(wb_stall), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait (bounded) for acceptance, return in cycle N+1.
    task automatic issue(input logic ld, input logic st, input logic [1:0] w, input logic uns,
                         input logic [31:0] base, input logic [31:0] imm, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdd);
        ex_load = ld; ex_store = st; ex_width = w; ex_unsigned = uns;
        ex_base = base; ex_imm = imm; ex_wdata = wd; ex_rd = rd; ex_rd_data = rdd;
        ex_valid = 1'b1;
        #1;
        for (int k = 0; k < 20 && ex_ready !== 1'b1; k++) cyc();
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: ex_ready=%b expected 1 within 20 cycles", ex_ready);
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL rst_ex_ready: got %b exp 0", ex_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b exp 0", wb_valid); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h exp 0", wb_data); end
        checks++; if (wb_exc !== 2'd0) begin errors++; $display("FAIL rst_wb_exc: got %0d exp 0", wb_exc); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd: got %0d exp 0", wb_rd); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req: got %b exp 0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL rst_dmem_we: got %b exp 0", dmem_we); end
        checks++; if (dmem_be !== 4'h0) begin errors++; $display("FAIL rst_dmem_be: got %h exp 0", dmem_be); end
        rst = 1'b0;
        cyc();
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", ex_ready); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd5, 32'h1234_5678);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_data: got %h exp 12345678", wb_data); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL nonmem_rd: got %0d exp 5", wb_rd); end
        checks++; if (wb_exc !== 2'd0) begin errors++; $display("FAIL nonmem_exc: got %0d exp 0", wb_exc); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req: got %b exp 0", dmem_req); end
        issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd6, 32'hDEAD_BEEF);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_data: got %h exp deadbeef", wb_data); end
        checks++; if (wb_rd !== 5'd6) begin errors++; $display("FAIL b2b_rd: got %0d exp 6", wb_rd); end
        cyc();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b exp 0", wb_valid); end
    endtask

    task automatic test_load_byte();
        logic [31:0] exp_data [2];
        exp_data[0] = 32'hFFFF_FF80;
        exp_data[1] = 32'h0000_0080;
        for (int u = 0; u < 2; u++) begin
            issue(1'b1, 1'b0, 2'd0, u[0], 32'h1000, 32'h3, 32'h0, 5'd7, 32'h0);
            for (int c = 0; c < 3; c++) begin
                checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL lb_req c%0d: got %b exp 1", c, dmem_req); end
                checks++; if (dmem_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h exp 1000", dmem_addr); end
                checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b exp 0", dmem_we); end
                if (c == 2) begin dmem_resp = 1'b1; dmem_rdata = 32'h80FF_1234; end
                cyc();
            end
            dmem_resp = 1'b0;
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lb_valid u%0d: got %b exp 1", u, wb_valid); end
            checks++; if (wb_data !== exp_data[u]) begin errors++; $display("FAIL lb_data u%0d: got %h exp %h", u, wb_data, exp_data[u]); end
            checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL lb_rd: got %0d exp 7", wb_rd); end
            checks++; if (wb_exc !== 2'd0) begin errors++; $display("FAIL lb_exc: got %0d exp 0", wb_exc); end
            checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b exp 0", dmem_req); end
            cyc();
        end
    endtask

    task automatic test_load_half_single_cycle();
        issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h1000, 32'h2, 32'h0, 5'd8, 32'h0);
        dmem_resp = 1'b1; dmem_rdata = 32'h8001_0000;
        cyc();
        dmem_resp = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lh_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h exp ffff8001", wb_data); end
        cyc();
    endtask

    task automatic test_store_half();
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h2000, 32'h2, 32'h0000_ABCD, 5'd9, 32'h0);
        for (int c = 0; c < 3; c++) begin
            checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL sh_req c%0d: got %b exp 1", c, dmem_req); end
            checks++; if (dmem_addr !== 32'h2000) begin errors++; $display("FAIL sh_addr: got %h exp 2000", dmem_addr); end
            checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b exp 1100", dmem_be); end
            checks++; if (dmem_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h exp abcdabcd", dmem_wdata); end
            checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b exp 1", dmem_we); end
            if (c == 2) dmem_resp = 1'b1;
            cyc();
        end
        dmem_resp = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sh_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL sh_rd: got %0d exp 0", wb_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL sh_data: got %h exp 0", wb_data); end
        checks++; if (wb_exc !== 2'd0) begin errors++; $display("FAIL sh_exc: got %0d exp 0", wb_exc); end
        cyc();
    endtask

    task automatic test_load_and_store();
        issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h7000, 32'h0, 32'h1122_3344, 5'd3, 32'h0);
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL ldst_we: got %b exp 1", dmem_we); end
        checks++; if (dmem_be !== 4'hF) begin errors++; $display("FAIL ldst_be: got %h exp f", dmem_be); end
        checks++; if (dmem_wdata !== 32'h1122_3344) begin errors++; $display("FAIL ldst_wdata: got %h exp 11223344", dmem_wdata); end
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        cyc();
        dmem_resp = 1'b0;
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL ldst_data: got %h exp 0", wb_data); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL ldst_rd: got %0d exp 0", wb_rd); end
        cyc();
    endtask

    task automatic test_misaligned();
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h1, 32'h0, 5'd4, 32'h0);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b exp 0", dmem_req); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mis_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_exc !== 2'd1) begin errors++; $display("FAIL mis_exc: got %0d exp 1", wb_exc); end
        checks++; if (wb_data !== 32'h3001) begin errors++; $display("FAIL mis_data: got %h exp 3001", wb_data); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL mis_rd: got %0d exp 0", wb_rd); end
        cyc();
        issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h3008, 32'h0, 32'h0, 5'd4, 32'h0);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL misd_req: got %b exp 0", dmem_req); end
        checks++; if (wb_exc !== 2'd1) begin errors++; $display("FAIL misd_exc: got %0d exp 1", wb_exc); end
        checks++; if (wb_data !== 32'h3008) begin errors++; $display("FAIL misd_data: got %h exp 3008", wb_data); end
        cyc();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd10, 32'h0);
        for (int c = 0; c < 10; c++) begin
            if (dmem_req !== 1'b1) break;
            n++;
            cyc();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL tmo_req_cycles: got %0d exp 4", n); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_exc !== 2'd2) begin errors++; $display("FAIL tmo_exc: got %0d exp 2", wb_exc); end
        checks++; if (wb_data !== 32'h4000) begin errors++; $display("FAIL tmo_data: got %h exp 4000", wb_data); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL tmo_rd: got %0d exp 0", wb_rd); end
        cyc();
    endtask

    task automatic test_stall();
        int xfers;
        xfers = 0;
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'h4, 32'h0, 5'd3, 32'h0);
        checks++; if (dmem_addr !== 32'h5004) begin errors++; $display("FAIL stall_addr: got %h exp 5004", dmem_addr); end
        dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D; wb_stall = 1'b1;
        cyc();
        dmem_resp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b exp 1", c, wb_valid); end
            checks++; if (wb_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall_data c%0d: got %h exp cafef00d", c, wb_data); end
            checks++; if (wb_rd !== 5'd3) begin errors++; $display("FAIL stall_rd c%0d: got %0d exp 3", c, wb_rd); end
            checks++; if (wb_exc !== 2'd0) begin errors++; $display("FAIL stall_exc c%0d: got %0d exp 0", c, wb_exc); end
            checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d: got %b exp 0", c, ex_ready); end
            if (wb_valid === 1'b1 && wb_stall === 1'b0) xfers++;
            cyc();
        end
        wb_stall = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b exp 1", wb_valid); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b exp 1", ex_ready); end
        if (wb_valid === 1'b1) xfers++;
        cyc();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_after_valid: got %b exp 0", wb_valid); end
        checks++; if (xfers != 1) begin errors++; $display("FAIL stall_xfers: got %0d exp 1", xfers); end
    endtask

    task automatic test_reset_mid_bus();
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 32'h0, 5'd2, 32'h0);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rbus_req: got %b exp 1", dmem_req); end
        rst = 1'b1;
        cyc();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rbus_req_drop: got %b exp 0", dmem_req); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rbus_valid: got %b exp 0", wb_valid); end
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL rbus_ready_in_rst: got %b exp 0", ex_ready); end
        rst = 1'b0;
        cyc();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rbus_valid_after: got %b exp 0", wb_valid); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rbus_ready_after: got %b exp 1", ex_ready); end
        issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h6000, 32'h1, 32'h0, 5'd2, 32'h0);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rbus_next_req: got %b exp 1", dmem_req); end
        dmem_resp = 1'b1; dmem_rdata = 32'h0000_AB00;
        cyc();
        dmem_resp = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rbus_next_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_data !== 32'h0000_00AB) begin errors++; $display("FAIL rbus_next_data: got %h exp 000000ab", wb_data); end
        checks++; if (wb_rd !== 5'd2) begin errors++; $display("FAIL rbus_next_rd: got %0d exp 2", wb_rd); end
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_base = '0; ex_imm = '0; ex_wdata = '0; ex_rd = '0; ex_rd_data = '0;
        ex_load = 1'b0; ex_store = 1'b0; ex_width = 2'd0; ex_unsigned = 1'b0;
        dmem_rdata = '0; dmem_resp = 1'b0; wb_stall = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_byte();
        test_load_half_single_cycle();
        test_store_half();
        test_load_and_store();
        test_misaligned();
        test_timeout();
        test_stall();
        test_reset_mid_bus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage_v2.md
MEMORY_STAGE_V2 -- requirements
Module: memory_stage_v2

Interface
REQ-001 Parameter XLEN, default 32, data and address width; SHALL be 32 or 64.
REQ-002 Parameter TIMEOUT, default 255, maximum bus-wait cycles; 0 SHALL disable the timeout.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Ports ex_valid in 1, ex_ready out 1  upstream handshake; transfer when both are high at a rising edge.
REQ-006 Ports ex_base in XLEN, ex_imm in XLEN, ex_wdata in XLEN, ex_rd in 5, ex_rd_data in XLEN  operands, destination, and pass-through result.
REQ-007 Ports ex_load in 1, ex_store in 1, ex_width in 2 (0=B,1=H,2=W,3=D), ex_unsigned in 1  operation decode.
REQ-008 Ports dmem_req out 1, dmem_we out 1, dmem_addr out XLEN, dmem_be out XLEN/8, dmem_wdata out XLEN  data bus request.
REQ-009 Ports dmem_rdata in XLEN, dmem_resp in 1  bus response; valid only while dmem_req is high.
REQ-010 Ports wb_valid out 1, wb_stall in 1, wb_rd out 5, wb_data out XLEN, wb_exc out 2 (0 none, 1 misaligned, 2 timeout)  registered writeback output.

Function
REQ-011 ex_ready SHALL be high only when state==IDLE and not (wb_valid and wb_stall).
REQ-012 Effective address SHALL be ex_base+ex_imm, modulo 2^XLEN, captured at acceptance.
REQ-013 Access SHALL be misaligned when any of the low log2(size) address bits is nonzero; D width with XLEN=32 SHALL also count as misaligned.
REQ-014 FSM states: IDLE, BUS. IDLE->BUS on acceptance of an aligned load or store; BUS->IDLE on dmem_resp or timeout.
REQ-015 Non-memory op (ex_load=ex_store=0) accepted in cycle N: wb_valid=1, wb_data=ex_rd_data, wb_exc=0 in cycle N+1.
REQ-016 Misaligned op accepted in cycle N: no bus request; wb_valid=1, wb_exc=1, wb_data=effective address, wb_rd=0 in cycle N+1.
REQ-017 In BUS, dmem_req SHALL stay high with address, we, be, and wdata constant until dmem_resp is sampled high.
REQ-018 dmem_addr SHALL be the effective address with its low log2(XLEN/8) bits cleared.
REQ-019 Store: dmem_be SHALL mark the size bytes at the byte offset; dmem_wdata SHALL carry ex_wdata replicated per byte lane.
REQ-020 Load: the selected lanes SHALL shift down by the offset, then sign-extend, or zero-extend if ex_unsigned, to XLEN.
REQ-021 dmem_resp sampled in cycle M: wb_valid=1, wb_exc=0 in M+1; load wb_data SHALL be the extended data; a store SHALL give wb_rd=0, wb_data=0.
REQ-022 dmem_resp in the same cycle as dmem_req's first cycle SHALL complete (single-cycle memory): accept N, req N+1, wb_valid N+2.
REQ-023 When TIMEOUT>0, a wait counter SHALL count BUS cycles; if it reaches TIMEOUT with no dmem_resp, then dmem_req SHALL drop, the FSM SHALL return to IDLE, and the next cycle SHALL give wb_valid=1, wb_exc=2, wb_rd=0, wb_data=effective address.
REQ-024 While wb_valid and wb_stall are both high, all wb_* outputs SHALL hold; a completing bus response SHALL wait in BUS with dmem_req low, the data held internally, and the result issued once the stall clears.
REQ-025 wb_valid SHALL clear the cycle after a transfer with wb_stall low, unless a new result completes that same cycle.
REQ-026 ex_load and ex_store both high SHALL be treated as a store.

Reset
REQ-027 While rst is high at a clock edge: FSM->IDLE, counter->0, wb_valid=0, wb_exc=0, wb_rd=0, wb_data=0, dmem_req=0, dmem_we=0, dmem_be=0.
REQ-028 rst asserted mid-BUS SHALL abandon the request (dmem_req=0 in the next cycle) and produce no writeback.
REQ-029 ex_ready SHALL be low while rst is high, and high in the first cycle after rst is released.

Verification
REQ-030 LB at address 0x1003, memory word 0x80FF_1234 (XLEN=32), resp after 3 cycles -> wb_data=0xFFFF_FF80 with ex_unsigned=0, and 0x0000_0080 with ex_unsigned=1.
REQ-031 SH at 0x2002 with ex_wdata=0xABCD -> dmem_addr=0x2000, dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, held until resp.
REQ-032 LW at 0x3001 -> no dmem_req, wb_exc=1, wb_data=0x3001 one cycle after acceptance.
REQ-033 TIMEOUT=4, no resp -> dmem_req high exactly 4 cycles, then wb_exc=2.
REQ-034 wb_stall held 5 cycles during load completion -> wb_* stable, ex_ready low, result delivered exactly once.
REQ-035 rst pulse during BUS -> dmem_req low next cycle, wb_valid stays 0, next op executes normally.
